// File: rtl/booth_sched_pkg.sv
// Shared types and default sizing for the booth multiplier scheduler.
package booth_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MUL_LAT = 4;

endpackage

// File: rtl/booth_mult_sched_if.sv
// Requester, response and multiplier-side signals of the booth multiplier scheduler.
interface booth_mult_sched_if
    import booth_sched_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_m;
    logic [N_REQ*WIDTH-1:0] req_q;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_p;
    logic                   rsp_ready;
    logic                   busy;
    logic                   mul_load;
    logic [WIDTH-1:0]       mul_m;
    logic [WIDTH-1:0]       mul_q;
    logic [2*WIDTH-1:0]     mul_p;

    // Requester fabric, consumer and multiplier taken together.
    modport master (
        output req_valid, req_m, req_q, rsp_ready, mul_p,
        input  req_ready, rsp_valid, rsp_id, rsp_p, busy, mul_load, mul_m, mul_q
    );

    modport slave (
        input  req_valid, req_m, req_q, rsp_ready, mul_p,
        output req_ready, rsp_valid, rsp_id, rsp_p, busy, mul_load, mul_m, mul_q
    );

endinterface

// File: rtl/booth_mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    always_comb begin
        logic found;
        int   idx;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
        if (found && en) grant[grant_id] = 1'b1;
    end

endmodule

// File: rtl/booth_mult_sched.sv
// Round-robin scheduler sharing one booth multiplier among N_REQ requesters.
module booth_mult_sched
    import booth_sched_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
    input logic clk,
    input logic reset,
    booth_mult_sched_if.slave bus
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;

    // Grant is suppressed while reset is held so req_ready reads 0 asynchronously too.
    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req      (bus.req_valid),
        .ptr      (rr_ptr),
        .en       ((state == IDLE) && !reset),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign bus.req_ready = grant;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            bus.mul_load  <= 1'b0;
            bus.mul_m     <= '0;
            bus.mul_q     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_p     <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        bus.mul_m    <= bus.req_m[grant_id*WIDTH +: WIDTH];
                        bus.mul_q    <= bus.req_q[grant_id*WIDTH +: WIDTH];
                        bus.rsp_id   <= grant_id;
                        bus.mul_load <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    bus.mul_load <= 1'b0;
                    cnt          <= CNT_W'(MUL_LAT);
                    state        <= RUN;
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bus.rsp_p     <= bus.mul_p;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        rr_ptr        <= (bus.rsp_id == ID_W'(N_REQ - 1)) ? '0
                                                                          : bus.rsp_id + ID_W'(1);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
